// File: rtl/mem_req_pkg.sv
// Shared helpers for the storage request path: width derivation, request
// entry sizing and the arbiter pointer reset value.
package mem_req_pkg;

    // Bits needed to index n items. Never returns less than 1.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // A queued request is {channel id, address}, id in the upper bits.
    function automatic int entry_w(input int id_w, input int addr_w);
        return id_w + addr_w;
    endfunction

    // The round-robin pointer resets to the last channel, so the first search
    // after reset starts at channel 0.
    function automatic int rr_ptr_rst(input int num_ch);
        return num_ch - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter for the request path.
// Build option MEM_REQ_RR_EN: defined gives round-robin, where the search
// starts one past the last granted channel and the pointer moves only when a
// grant is consumed (enable). Undefined gives fixed priority, lowest index wins.
module rr_arbiter
    import mem_req_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int ID_W   = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [ID_W-1:0]   grant_idx
);

`ifdef MEM_REQ_RR_EN
    logic [ID_W-1:0] rr_ptr;

    // Remember the last channel whose request was actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= ID_W'(rr_ptr_rst(NUM_CH));
        end else if (enable) begin
            rr_ptr <= grant_idx;
        end
    end

    // Walk from farthest to nearest after rr_ptr; the nearest requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (((req >> idx) & NUM_CH'(1)) != '0) begin
                grant     = NUM_CH'(1) << idx;
                grant_idx = ID_W'(idx);
            end
        end
    end
`else
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, enable};

    // Walk from highest to lowest index; the lowest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (((req >> k) & NUM_CH'(1)) != '0) begin
                grant     = NUM_CH'(1) << k;
                grant_idx = ID_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_req_path.sv
// Request path from NUM_CH core storage ports to the storage sequencer.
// One request per cycle is arbitrated into a show-ahead FIFO drained by a
// valid/ready handshake. Arbitration policy selected by MEM_REQ_RR_EN
// (see rr_arbiter); the port list is the same in both builds.
module mem_req_path
    import mem_req_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int ADDR_W = 8,
    parameter  int DEPTH  = 8,
    localparam int ID_W   = clog2_min1(NUM_CH),
    localparam int LVL_W  = clog2_min1(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_ce,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic                     out_valid,
    output logic [ID_W-1:0]          out_id,
    output logic [ADDR_W-1:0]        out_addr,
    input  logic                     out_ready,
    output logic [LVL_W-1:0]         level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W   = clog2_min1(DEPTH);
    localparam int ENTRY_W = entry_w(ID_W, ADDR_W);

    logic [NUM_CH-1:0]  eligible;
    logic [NUM_CH-1:0]  grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ADDR_W-1:0]  grant_addr;
    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_nxt;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] mem [DEPTH];

    // A channel still seeing its ack is holding the already-accepted request.
    assign eligible  = ch_ce & ~ch_ack;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = (eligible != '0) && (!full || pop);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (eligible),
        .enable    (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_addr = ADDR_W'(ch_addr >> (int'(grant_idx) * ADDR_W));

    // Entry storage; contents are left as-is on reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {grant_idx, grant_addr};
        end
    end

    // Occupancy moves only when exactly one of push/pop happens.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Pointers, occupancy flags and the per-channel acceptance pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ch_ack <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level  <= level_nxt;
            full   <= (level_nxt == LVL_W'(DEPTH));
            empty  <= (level_nxt == '0);
            ch_ack <= push ? grant : '0;
        end
    end

    // Show-ahead head read, zeroed while nothing is queued.
    assign head     = mem[rd_ptr];
    assign out_id   = empty ? '0 : head[ENTRY_W-1 -: ID_W];
    assign out_addr = empty ? '0 : head[ADDR_W-1:0];

endmodule
